// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file: read ports,
// two write ports, reservation port and the busy summary.
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [1:0]                   wr_en;
    logic [2*ADDR_WIDTH-1:0]      wr_addr;
    logic [2*DATA_WIDTH-1:0]      wr_data;
    logic                         resv_en;
    logic [ADDR_WIDTH-1:0]        resv_addr;
    logic                         busy_any;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, resv_en, resv_addr,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised MIPS register file: N combinational read ports, two prioritised
// write ports (W1 wins), hardwired $zero, optional write bypass, busy scoreboard.
module regfile_mp #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter int                    ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int                    NUM_RD     = 2,
    parameter int                    BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h10010200),
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = DATA_WIDTH'(32'h10008000)
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam logic [NUM_REGS-1:0]   ONE_HOT0  = NUM_REGS'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]          r_busy;
    logic                         r_busy_any;

    logic [ADDR_WIDTH-1:0]        w_wa0, w_wa1;
    logic [DATA_WIDTH-1:0]        w_wd0, w_wd1;
    logic                         w_we0, w_we1;
    logic [NUM_REGS-1:0]          w_clr, w_set, w_busy_next;
    logic [ADDR_WIDTH-1:0]        w_ra;
    logic                         w_hit0, w_hit1, w_resv_hit;
    logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]            w_rd_busy;

    assign w_wa0 = bus.wr_addr[0 +: ADDR_WIDTH];
    assign w_wa1 = bus.wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wd0 = bus.wr_data[0 +: DATA_WIDTH];
    assign w_wd1 = bus.wr_data[DATA_WIDTH +: DATA_WIDTH];
    // Data writes to $zero are suppressed here so the stored reg 0 stays 0.
    assign w_we0 = bus.wr_en[0] && (w_wa0 != ZERO_ADDR);
    assign w_we1 = bus.wr_en[1] && (w_wa1 != ZERO_ADDR);

    // Next busy vector: commits clear, a same-cycle reservation re-sets, bit 0 never busy.
    always_comb begin
        w_clr       = (bus.wr_en[0] ? (ONE_HOT0 << w_wa0) : {NUM_REGS{1'b0}})
                    | (bus.wr_en[1] ? (ONE_HOT0 << w_wa1) : {NUM_REGS{1'b0}});
        w_set       = bus.resv_en ? (ONE_HOT0 << bus.resv_addr) : {NUM_REGS{1'b0}};
        w_busy_next = ((r_busy & ~w_clr) | w_set) & ~ONE_HOT0;
    end

    // Register array, busy bits and busy summary; W1 is applied last so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 29) ? SP_INIT :
                             (i == 28) ? GP_INIT : {DATA_WIDTH{1'b0}};
            end
            r_busy     <= {NUM_REGS{1'b0}};
            r_busy_any <= 1'b0;
        end else begin
            if (w_we0) r_regs[w_wa0] <= w_wd0;
            if (w_we1) r_regs[w_wa1] <= w_wd1;
            r_busy     <= w_busy_next;
            r_busy_any <= |w_busy_next;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        w_rd_data  = {(NUM_RD*DATA_WIDTH){1'b0}};
        w_rd_busy  = {NUM_RD{1'b0}};
        w_ra       = ZERO_ADDR;
        w_hit0     = 1'b0;
        w_hit1     = 1'b0;
        w_resv_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra       = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_hit0     = w_we0 && (w_wa0 == w_ra);
            w_hit1     = w_we1 && (w_wa1 == w_ra);
            w_resv_hit = bus.resv_en && (bus.resv_addr == w_ra);
            if ((BYPASS != 0) && w_hit1) begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_wd1;
            end else if ((BYPASS != 0) && w_hit0) begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_wd0;
            end else begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra];
            end
            if ((BYPASS != 0) && (w_hit0 || w_hit1) && !w_resv_hit) begin
                w_rd_busy[i] = 1'b0;
            end else begin
                w_rd_busy[i] = r_busy[w_ra];
            end
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.busy_any = r_busy_any;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised + directed bench for regfile_mp: two instances (32x32 bypassing,
// 64x64 4-port non-bypassing) against an array-based model through a scoreboard queue.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus_a ();
    regfile_mp_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_RD(4)) bus_b ();

    regfile_mp #(.BYPASS(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_mp #(.DATA_WIDTH(64), .NUM_REGS(64), .NUM_RD(4), .BYPASS(0))
        u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [1:0]  en;
        int          wa0, wa1;
        logic [63:0] wd0, wd1;
        logic        resv;
        int          ra;
        int          rd [4];
    } in_t;

    typedef struct {
        string       tag;
        int          d;
        int          p;
        logic [63:0] data;
        logic        busy;
        int          any;   // -1: not compared
    } exp_t;

    exp_t        q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] m_mem  [2][64];
    logic        m_busy [2][64];

    function automatic in_t cur_in(int d);
        in_t v;
        if (d == 0) begin
            v.en   = bus_a.wr_en;
            v.wa0  = int'(bus_a.wr_addr[4:0]);
            v.wa1  = int'(bus_a.wr_addr[9:5]);
            v.wd0  = 64'(bus_a.wr_data[31:0]);
            v.wd1  = 64'(bus_a.wr_data[63:32]);
            v.resv = bus_a.resv_en;
            v.ra   = int'(bus_a.resv_addr);
            for (int p = 0; p < 4; p++) v.rd[p] = (p < 2) ? int'(bus_a.rd_addr[p*5 +: 5]) : 0;
        end else begin
            v.en   = bus_b.wr_en;
            v.wa0  = int'(bus_b.wr_addr[5:0]);
            v.wa1  = int'(bus_b.wr_addr[11:6]);
            v.wd0  = bus_b.wr_data[63:0];
            v.wd1  = bus_b.wr_data[127:64];
            v.resv = bus_b.resv_en;
            v.ra   = int'(bus_b.resv_addr);
            for (int p = 0; p < 4; p++) v.rd[p] = int'(bus_b.rd_addr[p*6 +: 6]);
        end
        return v;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 64; r++) begin
                m_mem[d][r]  = (r == 29) ? 64'h10010200 : (r == 28) ? 64'h10008000 : 64'h0;
                m_busy[d][r] = 1'b0;
            end
        end
    endfunction

    function automatic void m_commit(int d, in_t v);
        if (v.en[0] && v.wa0 != 0) m_mem[d][v.wa0] = v.wd0;
        if (v.en[1] && v.wa1 != 0) m_mem[d][v.wa1] = v.wd1;
        if (v.en[0]) m_busy[d][v.wa0] = 1'b0;
        if (v.en[1]) m_busy[d][v.wa1] = 1'b0;
        if (v.resv && v.ra != 0) m_busy[d][v.ra] = 1'b1;
    endfunction

    // Expected outputs for the inputs currently applied, pushed to the scoreboard.
    task automatic push_exp(string tag);
        in_t  v;
        exp_t e;
        bit   byp, wr, any;
        int   a;
        for (int d = 0; d < 2; d++) begin
            v   = cur_in(d);
            byp = (d == 0);
            any = 1'b0;
            for (int r = 0; r < 64; r++) any |= m_busy[d][r];
            for (int p = 0; p < ((d == 0) ? 2 : 4); p++) begin
                a  = v.rd[p];
                wr = (a != 0) && ((v.en[0] && v.wa0 == a) || (v.en[1] && v.wa1 == a));
                e.tag = tag; e.d = d; e.p = p; e.any = int'(any);
                if (a == 0)                              e.data = 64'h0;
                else if (byp && v.en[1] && v.wa1 == a)   e.data = v.wd1;
                else if (byp && v.en[0] && v.wa0 == a)   e.data = v.wd0;
                else                                     e.data = m_mem[d][a];
                e.busy = (a != 0) && m_busy[d][a] && !(byp && wr && !(v.resv && v.ra == a));
                q.push_back(e);
            end
        end
    endtask

    task automatic push_const(string tag, int d, int p, logic [63:0] data, logic busy, int any);
        exp_t e;
        e.tag = tag; e.d = d; e.p = p; e.data = data; e.busy = busy; e.any = any;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_commit(0, cur_in(0));
            m_commit(1, cur_in(1));
        end
        #1;
    endtask

    task automatic set_both(logic [1:0] en, int wa0, logic [63:0] wd0, int wa1, logic [63:0] wd1,
                            logic resv, int ra, int r0, int r1);
        bus_a.wr_en     = en;
        bus_a.wr_addr   = {5'(wa1), 5'(wa0)};
        bus_a.wr_data   = {wd1[31:0], wd0[31:0]};
        bus_a.resv_en   = resv;
        bus_a.resv_addr = 5'(ra);
        bus_a.rd_addr   = {5'(r1), 5'(r0)};
        bus_b.wr_en     = en;
        bus_b.wr_addr   = {6'(wa1), 6'(wa0)};
        bus_b.wr_data   = {wd1, wd0};
        bus_b.resv_en   = resv;
        bus_b.resv_addr = 6'(ra);
        bus_b.rd_addr   = {6'(r1), 6'(r0), 6'(r1), 6'(r0)};
    endtask

    function automatic int pick(int d);
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 28 + int'($urandom_range(0, 1));
            2:       return (d == 0) ? 31 : 63;
            3:       return int'($urandom_range(0, (d == 0) ? 31 : 63));
            default: return 8 + int'($urandom_range(0, 4));
        endcase
    endfunction

    task automatic rand_in();
        bus_a.wr_en     = 2'($urandom_range(0, 3));
        bus_a.wr_addr   = {5'(pick(0)), 5'(pick(0))};
        bus_a.wr_data   = {$urandom, $urandom};
        bus_a.resv_en   = 1'($urandom_range(0, 1));
        bus_a.resv_addr = 5'(pick(0));
        bus_a.rd_addr   = {5'(pick(0)), 5'(pick(0))};
        bus_b.wr_en     = 2'($urandom_range(0, 3));
        bus_b.wr_addr   = {6'(pick(1)), 6'(pick(1))};
        bus_b.wr_data   = {$urandom, $urandom, $urandom, $urandom};
        bus_b.resv_en   = 1'($urandom_range(0, 1));
        bus_b.resv_addr = 6'(pick(1));
        bus_b.rd_addr   = {6'(pick(1)), 6'(pick(1)), 6'(pick(1)), 6'(pick(1))};
    endtask

    // Monitor: on each falling edge compare every pending expectation with the DUT.
    initial begin
        exp_t        e;
        logic [63:0] ad;
        logic        ab, aa;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                e = q.pop_front();
                if (e.d == 0) begin
                    ad = 64'(bus_a.rd_data[e.p*32 +: 32]);
                    ab = bus_a.rd_busy[e.p];
                    aa = bus_a.busy_any;
                end else begin
                    ad = bus_b.rd_data[e.p*64 +: 64];
                    ab = bus_b.rd_busy[e.p];
                    aa = bus_b.busy_any;
                end
                n_checks++;
                if (ad === e.data && ab === e.busy && (e.any < 0 || aa === 1'(e.any))) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s dut%0d port%0d: got data=%h busy=%b any=%b, expected data=%h busy=%b any=%0d",
                             e.tag, e.d, e.p, ad, ab, aa, e.data, e.busy, e.any);
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 0, 0);
        m_reset();
        #2 rst = 1'b1;
        set_both(2'b01, 5, 64'hABCD, 0, 64'h0, 1'b1, 12, 5, 12);
        tick();
        // Mid-cycle reset: pending write to reg 5 and reservation of reg 12 are discarded.
        rst = 1'b0;
        m_reset();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 29, 28);
        bus_b.rd_addr = {6'd12, 6'd5, 6'd28, 6'd29};
        push_const("rst_sp", 0, 0, 64'h10010200, 1'b0, 0);
        push_const("rst_gp", 0, 1, 64'h10008000, 1'b0, 0);
        push_const("rst_sp_b", 1, 0, 64'h10010200, 1'b0, 0);
        push_const("rst_r5_b", 1, 2, 64'h0, 1'b0, 0);
        push_const("rst_r12_b", 1, 3, 64'h0, 1'b0, 0);
        push_exp("rst_model");
        tick();
        rst = 1'b1;

        set_both(2'b01, 8, 64'hDEADBEEF, 0, 64'h0, 1'b0, 0, 8, 0);
        push_exp("wr8"); tick();
        set_both(2'b01, 0, 64'h1234, 0, 64'h0, 1'b0, 0, 8, 0);
        push_const("rd8", 0, 0, 64'hDEADBEEF, 1'b0, 0);
        push_const("rd8_b", 1, 0, 64'hDEADBEEF, 1'b0, 0);
        push_exp("wr0"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 0, 8);
        push_const("rd0", 0, 0, 64'h0, 1'b0, 0);
        push_exp("rd0_model"); tick();

        set_both(2'b11, 9, 64'h1111, 9, 64'h2222, 1'b0, 0, 9, 9);
        push_const("prio_bypass", 0, 0, 64'h2222, 1'b0, 0);
        push_const("prio_nobypass_b", 1, 0, 64'h0, 1'b0, 0);
        push_exp("prio"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 9, 9);
        push_const("prio_stored", 0, 0, 64'h2222, 1'b0, 0);
        push_const("prio_stored_b", 1, 1, 64'h2222, 1'b0, 0);
        push_exp("prio_next"); tick();

        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b1, 10, 10, 10);
        push_exp("resv10"); tick();
        set_both(2'b10, 0, 64'h0, 10, 64'hA5A5, 1'b0, 0, 10, 10);
        push_const("commit_bypass_busy", 0, 0, 64'hA5A5, 1'b0, 1);
        push_const("commit_nobypass_busy_b", 1, 0, 64'h0, 1'b1, 1);
        push_exp("commit10"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 10, 10);
        push_const("commit_done", 0, 0, 64'hA5A5, 1'b0, 0);
        push_exp("commit_next"); tick();

        set_both(2'b01, 11, 64'h77, 0, 64'h0, 1'b1, 11, 11, 11);
        push_exp("collide"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b1, 0, 11, 0);
        push_const("collide_busy", 0, 0, 64'h77, 1'b1, 1);
        push_const("collide_busy_b", 1, 0, 64'h77, 1'b1, 1);
        push_exp("resv0"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 0, 11);
        push_const("resv0_notbusy", 0, 0, 64'h0, 1'b0, 1);
        push_exp("resv0_next"); tick();

        for (int c = 0; c < 300; c++) begin
            rand_in();
            if (c == 150) begin
                rst = 1'b0;
                m_reset();
                push_exp("rand_rst");
                tick();
                rst = 1'b1;
            end else begin
                push_exp("rand");
                tick();
            end
        end

        set_both(2'b01, 63, 64'h0123456789ABCDEF, 0, 64'h0, 1'b1, 40, 63, 63);
        push_exp("wr63"); tick();
        set_both(2'b00, 0, 64'h0, 0, 64'h0, 1'b0, 0, 63, 63);
        for (int p = 0; p < 4; p++) push_const("rd63_b", 1, p, 64'h0123456789ABCDEF, 1'b0, 1);
        push_exp("rd63"); tick();
        rst = 1'b0;
        m_reset();
        bus_b.rd_addr = {6'd40, 6'd63, 6'd40, 6'd63};
        push_const("rst63_b", 1, 0, 64'h0, 1'b0, 0);
        push_const("rst40_b", 1, 1, 64'h0, 1'b0, 0);
        push_exp("rst_sweep");
        tick();
        rst = 1'b1;

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
